// File: rtl/mdu_pkg.sv
// Op-code constants shared by the E-stage MDU, the D-stage controller and the hazard unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, computes the result on accept and
// models the multi-cycle latency with a down-counter that drives E_busy.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_Ctr,
  input  logic        E_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  output logic        E_busy,
  output logic [31:0] E_MDU_Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
  logic        dz_q, dz_d;

  logic               accept;
  logic               b_zero;
  logic signed [63:0] a_sx, b_sx;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  assign E_busy = (cnt_q != 4'd0);
  assign accept = E_start & ~E_busy & ~Req & is_md_op(E_MDU_Ctr);

  assign a_sx   = 64'($signed(E_A));
  assign b_sx   = 64'($signed(E_B));
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // A zero divisor is swapped for 1 so the datapath never divides by zero;
  // the dz flag suppresses the commit of that bogus result anyway.
  assign b_zero = (E_B == 32'd0);
  assign div_b  = b_zero ? 32'd1 : E_B;
  assign quot_s = $signed(E_A) / $signed(div_b);
  assign rem_s  = $signed(E_A) % $signed(div_b);
  assign quot_u = E_A / div_b;
  assign rem_u  = E_A % div_b;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    thi_d = thi_q;
    tlo_d = tlo_q;
    dz_d  = dz_q;
    if (accept) begin
      dz_d = 1'b0;
      case (E_MDU_Ctr)
        MDU_MULT: begin
          cnt_d = 4'(MULT_CYCLES);
          {thi_d, tlo_d} = prod_s;
        end
        MDU_MULTU: begin
          cnt_d = 4'(MULT_CYCLES);
          {thi_d, tlo_d} = prod_u;
        end
        MDU_DIV: begin
          cnt_d = 4'(DIV_CYCLES);
          thi_d = rem_s;
          tlo_d = quot_s;
          dz_d  = b_zero;
        end
        default: begin
          cnt_d = 4'(DIV_CYCLES);
          thi_d = rem_u;
          tlo_d = quot_u;
          dz_d  = b_zero;
        end
      endcase
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if ((cnt_q == 4'd1) && !dz_q) begin
        hi_d = thi_q;
        lo_d = tlo_q;
      end
    end else if (!Req) begin
      if (E_MDU_Ctr == MDU_MTHI) hi_d = E_A;
      if (E_MDU_Ctr == MDU_MTLO) lo_d = E_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      thi_q <= 32'd0;
      tlo_q <= 32'd0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      dz_q  <= dz_d;
    end
  end

  always_comb begin
    case (E_MDU_Ctr)
      MDU_MFHI: E_MDU_Out = hi_q;
      MDU_MFLO: E_MDU_Out = lo_q;
      default:  E_MDU_Out = 32'd0;
    endcase
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
